// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: deserializes 11-bit frames into scan codes and tracks
// make/break sequences so key_raw holds the code of the currently held key.
module ps2_key_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_raw,
  output logic       key_valid,
  output logic       key_break,
  output logic       frame_err
);

  localparam int unsigned TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (TO_BITS > 16) ? TO_BITS : 16;
  localparam logic [7:0]  BREAK_CODE = 8'hF0;
  localparam logic [7:0]  EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic             ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
  logic             ps2_data_s1_q, ps2_data_s2_q;
  logic             fe_c;
  logic             timeout_c;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             break_pending_q, break_pending_d;
  logic             ext_pending_q, ext_pending_d;
  logic [7:0]       key_raw_q, key_raw_d;
  logic             key_valid_q, key_valid_d;
  logic             key_break_q, key_break_d;
  logic             frame_err_q, frame_err_d;

  // Synchronizers idle high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2_clk_s1_q   <= 1'b1;
      ps2_clk_s2_q   <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_data_s1_q  <= 1'b1;
      ps2_data_s2_q  <= 1'b1;
    end else begin
      ps2_clk_s1_q   <= ps2_clk;
      ps2_clk_s2_q   <= ps2_clk_s1_q;
      ps2_clk_prev_q <= ps2_clk_s2_q;
      ps2_data_s1_q  <= ps2_data;
      ps2_data_s2_q  <= ps2_data_s1_q;
    end
  end

  assign fe_c      = ~ps2_clk_s2_q & ps2_clk_prev_q;
  assign timeout_c = (state_q != ST_IDLE) && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 8'h00;
      parity_q        <= 1'b0;
      to_cnt_q        <= '0;
      break_pending_q <= 1'b0;
      ext_pending_q   <= 1'b0;
      key_raw_q       <= 8'h00;
      key_valid_q     <= 1'b0;
      key_break_q     <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      to_cnt_q        <= to_cnt_d;
      break_pending_q <= break_pending_d;
      ext_pending_q   <= ext_pending_d;
      key_raw_q       <= key_raw_d;
      key_valid_q     <= key_valid_d;
      key_break_q     <= key_break_d;
      frame_err_q     <= frame_err_d;
    end
  end

  // Frame FSM, timeout supervision and make/break tracking.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    parity_d        = parity_q;
    break_pending_d = break_pending_q;
    ext_pending_d   = ext_pending_q;
    key_raw_d       = key_raw_q;
    key_valid_d     = 1'b0;
    key_break_d     = 1'b0;
    frame_err_d     = 1'b0;

    if ((state_q == ST_IDLE) || fe_c) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end

    if (fe_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ps2_data_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {ps2_data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = ps2_data_s2_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (ps2_data_s2_q && ((^shift_q) ^ parity_q)) begin
            if (shift_q == BREAK_CODE) begin
              break_pending_d = 1'b1;
            end else if (shift_q == EXT_CODE) begin
              ext_pending_d = 1'b1;
            end else begin
              key_valid_d = 1'b1;
              key_break_d = break_pending_q;
              if (!break_pending_q) begin
                key_raw_d = shift_q;
              end else if (shift_q == key_raw_q) begin
                key_raw_d = 8'h00;
              end
              break_pending_d = 1'b0;
              ext_pending_d   = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_c) begin
      // Abandon the partial frame and any half-received prefix sequence.
      state_d         = ST_IDLE;
      bit_cnt_d       = 3'd0;
      frame_err_d     = 1'b1;
      break_pending_d = 1'b0;
      ext_pending_d   = 1'b0;
    end
  end

  assign key_raw   = key_raw_q;
  assign key_valid = key_valid_q;
  assign key_break = key_break_q;
  assign frame_err = frame_err_q;

endmodule
